// File: rtl/axi_rd_arbiter.sv
// ----------------------------------------------------------------------------
// axi_rd_arbiter
//   Shares one AXI4 read master port (AR/R channels) between two requesters:
//   [0] = instruction-memory refill, [1] = data-memory load. One burst is in
//   flight at a time; the grant is round-robin and is held until the R beat
//   carrying RLAST has transferred. R beats are routed to the owner only.
//
// Ports
//   CLK, RST        core clock, asynchronous active-low reset
//   S_AR*           per-requester address channel (packed {req1, req0})
//   S_R*            read data broadcast, per-requester RVALID/RREADY
//   M_AXI_AR*       registered address channel towards the slave
//   M_AXI_R*        read data channel from the slave
//   GRANT           one-hot owner of the current burst, 00 when idle
// ----------------------------------------------------------------------------
module axi_rd_arbiter #(
   parameter int unsigned C_M_AXI_ADDR_WIDTH = 32,
   parameter int unsigned C_M_AXI_DATA_WIDTH = 32
) (
   input  logic                            CLK,
   input  logic                            RST,
   // requester address channels
   input  logic [2*C_M_AXI_ADDR_WIDTH-1:0] S_ARADDR,
   input  logic [15:0]                     S_ARLEN,
   input  logic [1:0]                      S_ARVALID,
   output logic [1:0]                      S_ARREADY,
   // requester read data channels
   output logic [C_M_AXI_DATA_WIDTH-1:0]   S_RDATA,
   output logic [1:0]                      S_RRESP,
   output logic                            S_RLAST,
   output logic [1:0]                      S_RVALID,
   input  logic [1:0]                      S_RREADY,
   // master address channel
   output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_ARADDR,
   output logic [7:0]                      M_AXI_ARLEN,
   output logic                            M_AXI_ARVALID,
   input  logic                            M_AXI_ARREADY,
   // master read data channel
   input  logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_RDATA,
   input  logic [1:0]                      M_AXI_RRESP,
   input  logic                            M_AXI_RLAST,
   input  logic                            M_AXI_RVALID,
   output logic                            M_AXI_RREADY,
   // current owner
   output logic [1:0]                      GRANT
);

   localparam int unsigned AW = C_M_AXI_ADDR_WIDTH;
   localparam int unsigned DW = C_M_AXI_DATA_WIDTH;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ADDR = 2'd1,
      ST_DATA = 2'd2
   } state_t;

   state_t        state;
   logic          rr_ptr;     // requester preferred when both ask
   logic          win;        // winner index for this IDLE cycle
   logic          any_req;
   logic          in_idle;
   logic          in_data;
   logic          beat_xfer;
   logic [AW-1:0] win_addr;
   logic [7:0]    win_len;

   assign any_req = |S_ARVALID;
   assign in_idle = (state == ST_IDLE);
   assign in_data = (state == ST_DATA);

   // Winner: a lone requester wins outright, a tie goes to rr_ptr.
   always_comb begin
      win = rr_ptr;
      case (S_ARVALID)
         2'b01:   win = 1'b0;
         2'b10:   win = 1'b1;
         default: win = rr_ptr;
      endcase
   end

   assign win_addr = win ? S_ARADDR[2*AW-1:AW] : S_ARADDR[AW-1:0];
   assign win_len  = win ? S_ARLEN[15:8]        : S_ARLEN[7:0];

   // Address accept is combinational so the requester handshake closes in
   // the IDLE cycle itself; the registered ARVALID follows one cycle later.
   assign S_ARREADY = (in_idle && any_req) ? (win ? 2'b10 : 2'b01) : 2'b00;

   // R channel steering: only the owner sees RVALID, only its RREADY counts.
   assign M_AXI_RREADY = in_data & (|(S_RREADY & GRANT));
   assign S_RVALID     = in_data ? ({2{M_AXI_RVALID}} & GRANT) : 2'b00;
   assign S_RDATA      = in_data ? M_AXI_RDATA : DW'(0);
   assign S_RRESP      = in_data ? M_AXI_RRESP : 2'b00;
   assign S_RLAST      = in_data & M_AXI_RLAST;

   assign beat_xfer = M_AXI_RVALID & M_AXI_RREADY;

   // Burst sequencer: IDLE -> ADDR -> DATA -> IDLE, outputs registered.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state         <= ST_IDLE;
         rr_ptr        <= 1'b0;
         GRANT         <= 2'b00;
         M_AXI_ARVALID <= 1'b0;
         M_AXI_ARADDR  <= AW'(0);
         M_AXI_ARLEN   <= 8'd0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (any_req) begin
                  M_AXI_ARADDR  <= win_addr;
                  M_AXI_ARLEN   <= win_len;
                  M_AXI_ARVALID <= 1'b1;
                  GRANT         <= win ? 2'b10 : 2'b01;
                  state         <= ST_ADDR;
               end
            end
            ST_ADDR: begin
               if (M_AXI_ARREADY) begin
                  M_AXI_ARVALID <= 1'b0;
                  M_AXI_ARADDR  <= AW'(0);
                  M_AXI_ARLEN   <= 8'd0;
                  state         <= ST_DATA;
               end
            end
            ST_DATA: begin
               // RLAST alone closes the burst; the other side is preferred next.
               if (beat_xfer && M_AXI_RLAST) begin
                  GRANT  <= 2'b00;
                  rr_ptr <= ~GRANT[1];
                  state  <= ST_IDLE;
               end
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule
